mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port Cond, input, 4 bits: Instr[31:28].
REQ-004 SHALL have port Op, input, 2 bits: Instr[27:26].
REQ-005 SHALL have port Funct, input, 6 bits: Instr[25:20].
REQ-006 SHALL have port Rd, input, 4 bits: Instr[15:12].
REQ-007 SHALL have port ALUFlags, input, 4 bits: {N,Z,C,V} from the ALU.
REQ-008 SHALL have outputs PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, each 1 bit: datapath enables/selects.
REQ-009 SHALL have outputs ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, each 2 bits: datapath selects; ImmSrc drives the extend unit.

Function
REQ-010 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
REQ-011 SHALL transition FETCH->DECODE unconditionally.
REQ-012 SHALL leave DECODE as follows: Op=01 -> MEMADR; Op=00 & Funct[5]=0 -> EXECUTER; Op=00 & Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> FETCH.
REQ-013 SHALL leave MEMADR for MEMREAD when Funct[0]=1, else MEMWRITE; MEMREAD->MEMWB; EXECUTER/EXECUTEI->ALUWB; MEMWB, MEMWRITE, ALUWB, BRANCH -> FETCH.
REQ-014 SHALL drive raw controls per state, with all unlisted signals 0:
- FETCH: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWRITE: AdrSrc=1, MemW=1.
- EXECUTER: ALUOp=1.
- EXECUTEI: ALUSrcB=01, ALUOp=1.
- ALUWB: RegW=1.
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-015 SHALL drive ImmSrc=Op and RegSrc={Op==01, Op==10} combinationally in every state.
REQ-016 SHALL, when ALUOp=1, decode Funct[4:1] as follows:
- 0100: ALUControl=00.
- 0010: ALUControl=01.
- 0000: ALUControl=10.
- 1100: ALUControl=11.
- 1010 (CMP): ALUControl=01, NoWrite=1.
- Any other value: ALUControl=00.
REQ-017 SHALL, when ALUOp=1, set FlagW[1]=Funct[0] and FlagW[0]=Funct[0]&(ALUControl==00 or 01).
REQ-018 SHALL, when ALUOp=0, set ALUControl=00 and FlagW=00.
REQ-019 SHALL hold flag registers NZ (from ALUFlags[3:2]) and CV (from ALUFlags[1:0]), each loaded at the clock edge when FlagW[i]&CondEx.
REQ-020 SHALL compute CondEx combinationally from Cond and the registered flags, per the ARM EQ..AL table (0000..1110); Cond=1111 SHALL give CondEx=0.
REQ-021 SHALL gate outputs as follows:
- RegWrite = RegW & CondEx & ~NoWrite.
- MemWrite = MemW & CondEx.
- PCWrite = NextPC | (CondEx & (Branch | (RegW & Rd==15))).
REQ-022 SHALL keep IRWrite and NextPC independent of CondEx, so the next fetch always proceeds.

Reset
REQ-023 SHALL, when rst_n=0 at a rising clk, set the state to FETCH and clear the NZ and CV registers to 0.
REQ-024 SHALL treat reset as overriding any in-flight state, including mid-MEMWRITE; the first cycle after release SHALL be FETCH with IRWrite=1 and PCWrite=1.
REQ-025 SHALL hold MemWrite=0 and RegWrite=0 while rst_n=0.

Configuration
REQ-026 SHALL, when macro MC_STATE_DBG_EN is defined, add output state_dbg, 4 bits, giving the state index (FETCH=0 .. BRANCH=9, in REQ-010 order).
REQ-027 SHALL, when MC_STATE_DBG_EN is undefined, omit that port with all other behaviour identical.

Verification
REQ-028 SHALL be verified for reset and fetch: hold rst_n=0 for 2 cycles then release -> FETCH outputs IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10; NZ=CV=0.
REQ-029 SHALL be verified for LDR: Op=01, Funct=011001, Cond=1110 -> sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; RegWrite=1 only in MEMWB; ImmSrc=01.
REQ-030 SHALL be verified for SUBS immediate: Op=00, Funct=100101, ALUFlags=0100 -> EXECUTEI with ALUControl=01; Z=1 latched; ALUWB RegWrite=1.
REQ-031 SHALL be verified for a conditional branch: after the Z flag is set, Op=10, Cond=0000 (EQ) -> BRANCH with PCWrite=1; repeating with Cond=0001 (NE) -> PCWrite=0.
REQ-032 SHALL be verified for CMP: Op=00, Funct=010101 -> FlagW=11 and RegWrite=0 in ALUWB; STR with Cond=0001 while Z=1 -> MemWrite=0 in MEMWRITE.
REQ-033 SHALL be verified for reset mid-store: assert rst_n=0 in MEMWRITE -> MemWrite=0 at the next edge and the state is FETCH.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle ARM-style control unit: Moore FSM, ALU decoder, condition check and flag registers.
// Optional MC_STATE_DBG_EN adds a 4-bit state_dbg output carrying the state index.
module mc_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl
`ifdef MC_STATE_DBG_EN
    ,
    output logic [3:0] state_dbg
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t     r_state, w_next;
    logic [1:0] r_nz, r_cv;

    logic       w_irw, w_npc, w_asa, w_adr, w_regw, w_memw, w_aluop, w_branch;
    logic [1:0] w_asb, w_rsrc, w_alu_ctl, w_flag_w;
    logic       w_nowrite, w_cond_ex;
    logic       w_n, w_z, w_c, w_v;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_nz    <= 2'b00;
            r_cv    <= 2'b00;
        end else begin
            r_state <= w_next;
            if (w_flag_w[1] && w_cond_ex) r_nz <= ALUFlags[3:2];
            if (w_flag_w[0] && w_cond_ex) r_cv <= ALUFlags[1:0];
        end
    end

    always_comb begin
        w_next   = r_state;
        w_irw    = 1'b0;
        w_npc    = 1'b0;
        w_asa    = 1'b0;
        w_adr    = 1'b0;
        w_regw   = 1'b0;
        w_memw   = 1'b0;
        w_aluop  = 1'b0;
        w_branch = 1'b0;
        w_asb    = 2'b00;
        w_rsrc   = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_next = S_DECODE;
                w_irw  = 1'b1;
                w_npc  = 1'b1;
                w_asa  = 1'b1;
                w_asb  = 2'b10;
                w_rsrc = 2'b10;
            end
            S_DECODE: begin
                w_asa  = 1'b1;
                w_asb  = 2'b10;
                w_rsrc = 2'b10;
                case (Op)
                    2'b01:   w_next = S_MEMADR;
                    2'b00:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                w_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
                w_asb  = 2'b01;
            end
            S_MEMREAD: begin
                w_next = S_MEMWB;
                w_adr  = 1'b1;
            end
            S_MEMWB: begin
                w_next = S_FETCH;
                w_rsrc = 2'b01;
                w_regw = 1'b1;
            end
            S_MEMWRITE: begin
                w_next = S_FETCH;
                w_adr  = 1'b1;
                w_memw = 1'b1;
            end
            S_EXECUTER: begin
                w_next  = S_ALUWB;
                w_aluop = 1'b1;
            end
            S_EXECUTEI: begin
                w_next  = S_ALUWB;
                w_asb   = 2'b01;
                w_aluop = 1'b1;
            end
            S_ALUWB: begin
                w_next = S_FETCH;
                w_regw = 1'b1;
            end
            S_BRANCH: begin
                w_next   = S_FETCH;
                w_asb    = 2'b01;
                w_rsrc   = 2'b10;
                w_branch = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_alu_ctl = 2'b00;
        w_flag_w  = 2'b00;
        if (w_aluop) begin
            case (Funct[4:1])
                4'b0100: w_alu_ctl = 2'b00;
                4'b0010: w_alu_ctl = 2'b01;
                4'b0000: w_alu_ctl = 2'b10;
                4'b1100: w_alu_ctl = 2'b11;
                4'b1010: w_alu_ctl = 2'b01;
                default: w_alu_ctl = 2'b00;
            endcase
            w_flag_w[1] = Funct[0];
            w_flag_w[0] = Funct[0] && (w_alu_ctl == 2'b00 || w_alu_ctl == 2'b01);
        end
    end

    // CMP suppresses the write in ALUWB, where ALUOp is already low, so decode it from the instruction.
    assign w_nowrite = (Op == 2'b00) && (Funct[4:1] == 4'b1010);

    assign w_n = r_nz[1];
    assign w_z = r_nz[0];
    assign w_c = r_cv[1];
    assign w_v = r_cv[0];

    always_comb begin
        w_cond_ex = 1'b0;
        case (Cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // Write strobes are also masked by rst_n so a store caught by reset never commits.
    assign RegWrite   = w_regw & w_cond_ex & ~w_nowrite & rst_n;
    assign MemWrite   = w_memw & w_cond_ex & rst_n;
    assign PCWrite    = w_npc | (w_cond_ex & (w_branch | (w_regw & (Rd == 4'd15))));
    assign IRWrite    = w_irw;
    assign AdrSrc     = w_adr;
    assign ALUSrcA    = w_asa;
    assign ALUSrcB    = w_asb;
    assign ResultSrc  = w_rsrc;
    assign ALUControl = w_alu_ctl;
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == 2'b01, Op == 2'b10};

`ifdef MC_STATE_DBG_EN
    assign state_dbg = r_state;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction reference model plus random instruction stream.
module tb_mc_controller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] Cond, Rd, ALUFlags;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;

    int errors = 0;
    int checks = 0;

    // Architectural flags as the model sees them: {N,Z} and {C,V}
    logic [1:0] m_nz, m_cv;

    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4,
                   P_MW = 5, P_ER = 6, P_EI = 7, P_WB = 8, P_BR = 9;

    logic [15:0] exp_q [8];
    logic [15:0] obs_q [8];
    int          ph_q  [8];
    int          n_cyc;

    mc_controller dut (
        .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ResultSrc(ResultSrc),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Bit map: 15 PCWrite,14 MemWrite,13 RegWrite,12 IRWrite,11 AdrSrc,10 ALUSrcA,
    // 9:8 ResultSrc,7:6 ALUSrcB,5:4 ImmSrc,3:2 RegSrc,1:0 ALUControl
    function automatic logic [15:0] obs_vec();
        return {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl};
    endfunction

    function automatic logic cond_ok(logic [3:0] cd, logic n, logic z, logic c, logic v);
        case (cd)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_ctl(logic [3:0] cmd);
        case (cmd)
            4'b0100: return 2'b00;
            4'b0010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            4'b1010: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [15:0] model_out(int ph, logic [3:0] cd, logic [1:0] op,
                                              logic [5:0] fn, logic [3:0] rd);
        logic ce, irw, npc, asa, adr, regw, memw, aluop, br, nowr, pcw;
        logic [1:0] asb, rs, ac;
        irw = 0; npc = 0; asa = 0; adr = 0; regw = 0; memw = 0; aluop = 0; br = 0;
        asb = 2'b00; rs = 2'b00;
        ce = cond_ok(cd, m_nz[1], m_nz[0], m_cv[1], m_cv[0]);
        case (ph)
            P_F:   begin irw = 1; npc = 1; asa = 1; asb = 2'b10; rs = 2'b10; end
            P_D:   begin asa = 1; asb = 2'b10; rs = 2'b10; end
            P_MA:  asb = 2'b01;
            P_MR:  adr = 1;
            P_MWB: begin rs = 2'b01; regw = 1; end
            P_MW:  begin adr = 1; memw = 1; end
            P_ER:  aluop = 1;
            P_EI:  begin asb = 2'b01; aluop = 1; end
            P_WB:  regw = 1;
            P_BR:  begin asb = 2'b01; rs = 2'b10; br = 1; end
            default: ;
        endcase
        ac   = aluop ? alu_ctl(fn[4:1]) : 2'b00;
        nowr = (op == 2'b00) && (fn[4:1] == 4'b1010);
        pcw  = npc | (ce & (br | (regw & (rd == 4'd15))));
        return {pcw, memw & ce, regw & ce & !nowr, irw, adr, asa, rs, asb, op,
                op == 2'b01, op == 2'b10, ac};
    endfunction

    // Runs one instruction from FETCH (entered at a negedge) back to the next FETCH,
    // recording observed and model vectors; comparisons are done by the callers.
    task automatic run_instr(input logic [3:0] cd, input logic [1:0] op, input logic [5:0] fn,
                             input logic [3:0] rd, input logic [3:0] fl);
        int  np;
        logic ce, fw1, fw0;
        ph_q[0] = P_F; ph_q[1] = P_D; np = 2;
        case (op)
            2'b01: begin
                ph_q[2] = P_MA;
                if (fn[0]) begin ph_q[3] = P_MR; ph_q[4] = P_MWB; np = 5; end
                else       begin ph_q[3] = P_MW; np = 4; end
            end
            2'b00: begin ph_q[2] = fn[5] ? P_EI : P_ER; ph_q[3] = P_WB; np = 4; end
            2'b10: begin ph_q[2] = P_BR; np = 3; end
            default: ;
        endcase
        Cond = cd; Op = op; Funct = fn; Rd = rd; ALUFlags = fl;
        for (int i = 0; i < np; i++) begin
            #1;
            obs_q[i] = obs_vec();
            exp_q[i] = model_out(ph_q[i], cd, op, fn, rd);
            if (ph_q[i] == P_ER || ph_q[i] == P_EI) begin
                ce  = cond_ok(cd, m_nz[1], m_nz[0], m_cv[1], m_cv[0]);
                fw1 = fn[0];
                fw0 = fn[0] && (alu_ctl(fn[4:1]) <= 2'b01);
                if (fw1 && ce) m_nz = fl[3:2];
                if (fw0 && ce) m_cv = fl[1:0];
            end
            @(negedge clk);
        end
        n_cyc = np;
    endtask

    task automatic test_reset();
        rst_n = 0; Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 0; ALUFlags = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (MemWrite !== 1'b0 || RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: got MemWrite=%b RegWrite=%b want 0 0", MemWrite, RegWrite);
        end
        rst_n = 1; m_nz = 2'b00; m_cv = 2'b00;
        // Z and C should be clear after reset: EQ and CS branches fall through, NE is taken
        run_instr(4'd0, 2'b10, 6'b100000, 4'd0, 4'h0);
        checks++;
        if (obs_q[0][15] !== 1'b1 || obs_q[0][12] !== 1'b1 || obs_q[0][7:6] !== 2'b10 ||
            obs_q[0][9:8] !== 2'b10) begin
            errors++;
            $display("FAIL reset_fetch: got %h want PCWrite,IRWrite=1 ALUSrcB,ResultSrc=10", obs_q[0]);
        end
        checks++;
        if (obs_q[2][15] !== 1'b0) begin
            errors++;
            $display("FAIL reset_z_clear: got PCWrite=%b want 0", obs_q[2][15]);
        end
        for (int i = 0; i < n_cyc; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_beq cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        run_instr(4'd2, 2'b10, 6'b100000, 4'd0, 4'h0);
        checks++;
        if (obs_q[2][15] !== 1'b0) begin
            errors++;
            $display("FAIL reset_c_clear: got PCWrite=%b want 0", obs_q[2][15]);
        end
        run_instr(4'd1, 2'b10, 6'b100000, 4'd0, 4'h0);
        checks++;
        if (obs_q[2][15] !== 1'b1) begin
            errors++;
            $display("FAIL reset_bne: got PCWrite=%b want 1", obs_q[2][15]);
        end
    endtask

    task automatic test_ldr();
        run_instr(4'hE, 2'b01, 6'b011001, 4'd3, 4'h0);
        checks++;
        if (n_cyc !== 5) begin
            errors++;
            $display("FAIL ldr_len: got %0d want 5", n_cyc);
        end
        for (int i = 0; i < n_cyc; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ldr cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
            checks++;
            if (obs_q[i][13] !== (i == 4) || obs_q[i][5:4] !== 2'b01) begin
                errors++;
                $display("FAIL ldr_regw_imm cyc%0d: got RegWrite=%b ImmSrc=%b want %b 01",
                         i, obs_q[i][13], obs_q[i][5:4], i == 4);
            end
        end
    endtask

    task automatic test_subs();
        run_instr(4'hE, 2'b00, 6'b100101, 4'd2, 4'b0100);
        checks++;
        if (obs_q[2][1:0] !== 2'b01 || obs_q[2][7:6] !== 2'b01) begin
            errors++;
            $display("FAIL subs_exec: got ALUControl=%b ALUSrcB=%b want 01 01", obs_q[2][1:0], obs_q[2][7:6]);
        end
        checks++;
        if (obs_q[3][13] !== 1'b1) begin
            errors++;
            $display("FAIL subs_aluwb: got RegWrite=%b want 1", obs_q[3][13]);
        end
        for (int i = 0; i < n_cyc; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL subs cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_branch();
        run_instr(4'd0, 2'b10, 6'b000000, 4'd0, 4'h0);
        checks++;
        if (obs_q[2][15] !== 1'b1) begin
            errors++;
            $display("FAIL beq_taken: got PCWrite=%b want 1", obs_q[2][15]);
        end
        run_instr(4'd1, 2'b10, 6'b000000, 4'd0, 4'h0);
        checks++;
        if (obs_q[2][15] !== 1'b0) begin
            errors++;
            $display("FAIL bne_not_taken: got PCWrite=%b want 0", obs_q[2][15]);
        end
        for (int i = 0; i < n_cyc; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bne cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_cmp_str();
        // CMP sets N=0 Z=1 C=1 V=0; both flag groups must load
        run_instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0110);
        checks++;
        if (obs_q[3][13] !== 1'b0 || obs_q[2][1:0] !== 2'b01) begin
            errors++;
            $display("FAIL cmp: got RegWrite=%b ALUControl=%b want 0 01", obs_q[3][13], obs_q[2][1:0]);
        end
        for (int i = 0; i < n_cyc; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL cmp cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        run_instr(4'd2, 2'b10, 6'b000000, 4'd0, 4'h0);
        checks++;
        if (obs_q[2][15] !== 1'b1) begin
            errors++;
            $display("FAIL cmp_c_loaded: got PCWrite=%b want 1", obs_q[2][15]);
        end
        run_instr(4'd1, 2'b01, 6'b011000, 4'd0, 4'h0);
        checks++;
        if (obs_q[3][14] !== 1'b0 || obs_q[3][11] !== 1'b1) begin
            errors++;
            $display("FAIL str_ne: got MemWrite=%b AdrSrc=%b want 0 1", obs_q[3][14], obs_q[3][11]);
        end
    endtask

    task automatic test_reset_midstore();
        Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'd0; ALUFlags = 4'h0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL midstore_pre: got MemWrite=%b want 1", MemWrite);
        end
        rst_n = 0; #1;
        checks++;
        if (MemWrite !== 1'b0 || RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL midstore_rst: got MemWrite=%b RegWrite=%b want 0 0", MemWrite, RegWrite);
        end
        @(negedge clk); #1;
        checks++;
        if (MemWrite !== 1'b0) begin
            errors++;
            $display("FAIL midstore_edge: got MemWrite=%b want 0", MemWrite);
        end
        rst_n = 1; m_nz = 2'b00; m_cv = 2'b00; #1;
        checks++;
        if (obs_vec() !== model_out(P_F, Cond, Op, Funct, Rd) || IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
            errors++;
            $display("FAIL midstore_fetch: got %h want %h", obs_vec(), model_out(P_F, Cond, Op, Funct, Rd));
        end
    endtask

    task automatic test_random();
        logic [3:0] cd, rd, fl;
        logic [1:0] op;
        logic [5:0] fn;
        for (int k = 0; k < 80; k++) begin
            cd = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) cd = 4'hE;
            op = 2'($urandom_range(0, 3));
            fn = 6'($urandom);
            if ($urandom_range(0, 1) == 1) fn[4:1] = 4'b0100 - 4'($urandom_range(0, 1)) * 4'b0010;
            if ($urandom_range(0, 4) == 0) fn[4:1] = 4'b1010;
            rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            fl = 4'($urandom);
            run_instr(cd, op, fn, rd, fl);
            for (int i = 0; i < n_cyc; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand k%0d cyc%0d (cond=%h op=%b fn=%b rd=%0d): got %h want %h",
                             k, i, cd, op, fn, rd, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        m_nz = 2'b00; m_cv = 2'b00;
        test_reset();
        test_ldr();
        test_subs();
        test_branch();
        test_cmp_str();
        test_reset_midstore();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
